hc_pipe_subtractor: RTL and testbench

- Pipelined W-bit subtractor/comparator built on the team's Han-Carlson prefix network. It is the inverse-direction companion of the combinational prefix adder.
- Computes DIFF = A - B - bin with B inverted and carry-in = ~bin, and derives borrow, signed overflow and compare flags.
- Sits on datapath operand streams behind a valid/ready handshake and absorbs downstream backpressure.
- Fixed 3-stage pipeline with per-stage bubble collapsing.

---
 rtl/hc_pipe_subtractor_pkg.sv | 20 ++
 rtl/hc_pipe_subtractor_if.sv | 32 +++
 rtl/hc_pipe_subtractor_prefix_level.sv | 23 ++
 rtl/hc_pipe_subtractor.sv | 128 ++++++++++++
 tb/tb_hc_pipe_subtractor.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/hc_pipe_subtractor_pkg.sv
// Shared types and constants for the Han-Carlson pipelined subtractor.
package hc_sub_pkg;

  localparam int HC_WIDTH  = 16;
  localparam int HC_LEVELS = $clog2(HC_WIDTH);

  typedef struct packed {
    logic bout;
    logic ovf;
    logic zero;
    logic lt_u;
    logic lt_s;
  } hc_flags_t;

  typedef struct packed {
    logic g;
    logic p;
  } gp_pair_t;

endpackage

// File: rtl/hc_pipe_subtractor_if.sv
// Operand/result stream bundle; master drives operands and out_ready, slave is the subtractor.
interface hc_sub_if
  import hc_sub_pkg::*;
#(
  parameter int WIDTH = HC_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;
  logic             zero;
  logic             lt_u;
  logic             lt_s;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf, zero, lt_u, lt_s
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf, zero, lt_u, lt_s
  );

endinterface

// File: rtl/hc_pipe_subtractor_prefix_level.sv
// One combinational prefix level: black cells at odd (ODD_ONLY=1) or even (ODD_ONLY=0)
// positions with i >= SPAN combine with position i-SPAN; all others pass through.
module hc_prefix_level
  import hc_sub_pkg::*;
#(
  parameter int WIDTH    = HC_WIDTH,
  parameter int SPAN     = 1,
  parameter bit ODD_ONLY = 1'b1
) (
  input  gp_pair_t [WIDTH-1:0] gp_i,
  output gp_pair_t [WIDTH-1:0] gp_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    if ((i >= SPAN) && (((i % 2) == 1) == ODD_ONLY)) begin : g_black
      assign gp_o[i].g = gp_i[i].g | (gp_i[i].p & gp_i[i-SPAN].g);
      assign gp_o[i].p = gp_i[i].p & gp_i[i-SPAN].p;
    end else begin : g_pass
      assign gp_o[i] = gp_i[i];
    end
  end

endmodule

// File: rtl/hc_pipe_subtractor.sv
// 3-stage A - B - bin subtractor/comparator on a Han-Carlson prefix network with
// bubble-collapsing valid/ready flow. Define HC_SUB_SAT_EN to saturate diff on overflow.
module hc_pipe_subtractor
  import hc_sub_pkg::*;
#(
  parameter int WIDTH = HC_WIDTH
) (
  input  logic    clk,
  input  logic    rst_n,
  hc_sub_if.slave bus
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int MSB    = WIDTH - 1;

  logic [3:1] vld_q;
  logic       ld1, ld2, ld3, acc;

  // A stage may load when empty or when its successor drains it this cycle.
  assign ld3          = ~vld_q[3] | bus.out_ready;
  assign ld2          = ~vld_q[2] | ld3;
  assign ld1          = ~vld_q[1] | ld2;
  assign acc          = bus.in_valid & ld1;
  assign bus.in_ready = ld1;

  // S1: bitwise generate/propagate against ~b
  gp_pair_t [WIDTH-1:0] gp1_d, gp1_q;
  logic                 cin1_q, amsb1_q;

  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      gp1_d[i].g = bus.a[i] & ~bus.b[i];
      gp1_d[i].p = ~(bus.a[i] ^ bus.b[i]);
    end
  end

  // S2: odd-position prefix tree, spans 1 .. WIDTH/2
  gp_pair_t [WIDTH-1:0] lvl [LEVELS+1];
  gp_pair_t [WIDTH-1:0] gp2_q;
  logic     [WIDTH-1:0] p0_1, p0_2_q;
  logic                 cin2_q, amsb2_q;

  assign lvl[0] = gp1_q;
  for (genvar l = 0; l < LEVELS; l++) begin : g_odd_lvl
    hc_prefix_level #(.WIDTH(WIDTH), .SPAN(1 << l), .ODD_ONLY(1'b1)) u_lvl (
      .gp_i (lvl[l]),
      .gp_o (lvl[l+1])
    );
  end

  always_comb begin
    for (int i = 0; i < WIDTH; i++) p0_1[i] = gp1_q[i].p;
  end

  // S3: even fix-up, carry injection, sum and flags
  gp_pair_t [WIDTH-1:0] gp3;
  logic     [WIDTH:0]   carry;
  logic     [WIDTH-1:0] diff_raw, diff_d, diff_q;
  logic                 ovf_d;
  hc_flags_t            flags_d, flags_q;

  hc_prefix_level #(.WIDTH(WIDTH), .SPAN(1), .ODD_ONLY(1'b0)) u_fix (
    .gp_i (gp2_q),
    .gp_o (gp3)
  );

  always_comb begin
    carry    = '0;
    carry[0] = cin2_q;
    for (int i = 0; i < WIDTH; i++) carry[i+1] = gp3[i].g | (gp3[i].p & cin2_q);
    diff_raw = p0_2_q ^ carry[WIDTH-1:0];
    // operand signs differ exactly when the ~b propagate bit at MSB is clear
    ovf_d         = ~p0_2_q[MSB] & (amsb2_q ^ diff_raw[MSB]);
    flags_d.bout  = ~carry[WIDTH];
    flags_d.ovf   = ovf_d;
    flags_d.zero  = ~|diff_raw;
    flags_d.lt_u  = ~carry[WIDTH];
    flags_d.lt_s  = diff_raw[MSB] ^ ovf_d;
    diff_d        = diff_raw;
`ifdef HC_SUB_SAT_EN
    if (ovf_d) diff_d = amsb2_q ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      gp1_q   <= '0;
      cin1_q  <= 1'b0;
      amsb1_q <= 1'b0;
      gp2_q   <= '0;
      p0_2_q  <= '0;
      cin2_q  <= 1'b0;
      amsb2_q <= 1'b0;
      diff_q  <= '0;
      flags_q <= '0;
    end else begin
      if (ld1) vld_q[1] <= bus.in_valid;
      if (ld2) vld_q[2] <= vld_q[1];
      if (ld3) vld_q[3] <= vld_q[2];
      if (acc) begin
        gp1_q   <= gp1_d;
        cin1_q  <= ~bus.bin;
        amsb1_q <= bus.a[MSB];
      end
      if (ld2 & vld_q[1]) begin
        gp2_q   <= lvl[LEVELS];
        p0_2_q  <= p0_1;
        cin2_q  <= cin1_q;
        amsb2_q <= amsb1_q;
      end
      if (ld3 & vld_q[2]) begin
        diff_q  <= diff_d;
        flags_q <= flags_d;
      end
    end
  end

  assign bus.out_valid = vld_q[3];
  assign bus.diff      = diff_q;
  assign bus.bout      = flags_q.bout;
  assign bus.ovf       = flags_q.ovf;
  assign bus.zero      = flags_q.zero;
  assign bus.lt_u      = flags_q.lt_u;
  assign bus.lt_s      = flags_q.lt_s;

endmodule

// File: tb/tb_hc_pipe_subtractor.sv
// Scoreboard bench for hc_pipe_subtractor; reference model honours HC_SUB_SAT_EN.
module tb_hc_pipe_subtractor;

  localparam int W = 16;
  typedef logic [W+4:0] res_t;  // {diff, bout, ovf, zero, lt_u, lt_s}

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   rdone  = 1'b0;
  res_t sb[$];

  always #5 clk = ~clk;

  hc_sub_if #(.WIDTH(W)) bus ();

  hc_pipe_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
    int   ua, ub, sa, sb_, bi, d, sd;
    logic [W-1:0] dv;
    logic bo, ov, zr, ls;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb_ = int'($signed(bv));
    bi = bv_in ? 1 : 0;
    d  = ua - ub - bi;
    sd = sa - sb_ - bi;
    dv = d[W-1:0];
    bo = (ua < ub + bi);
    ov = (sd > 32767) || (sd < -32768);
    zr = (dv == '0);
    ls = (sd < 0);
`ifdef HC_SUB_SAT_EN
    if (ov) dv = (sa >= 0) ? 16'h7FFF : 16'h8000;
`endif
    return {dv, bo, ov, zr, bo, ls};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  function automatic res_t dut_res();
    return {bus.diff, bus.bout, bus.ovf, bus.zero, bus.lt_u, bus.lt_s};
  endfunction

  // Monitor: compare emitted results, record accepted beats, check stall stability.
  initial begin
    logic stall_q;
    res_t held, got;
    stall_q = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        stall_q = 1'b0;
      end else begin
        got = dut_res();
        if (stall_q) chk("hold_stable", {10'd0, bus.out_valid, got}, {10'd0, 1'b1, held});
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result got=%h want=none", got);
          end else begin
            chk("result", {11'd0, got}, {11'd0, sb.pop_front()});
          end
        end
        if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.a, bus.b, bus.bin));
        stall_q = bus.out_valid && !bus.out_ready;
        held    = got;
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.b        = bv;
    bus.bin      = bv_in;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout got=in_ready0 want=in_ready1");
    end
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_op();
    logic [W-1:0] corner [5];
    corner = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    if ($urandom_range(0, 4) == 0) return corner[$urandom_range(0, 4)];
    return W'($urandom());
  endfunction

  initial begin
    logic [2:0]   lat;
    logic [W-1:0] ra, rb;
    int           n;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    chk("rst_outputs",   {11'd0, dut_res()},     32'd0);
    @(posedge clk);
    #1;

    // latency: result visible in the third cycle after the accepting edge
    send(16'h0005, 16'h0003, 1'b0);
    @(negedge clk) lat[2] = bus.out_valid;
    @(negedge clk) lat[1] = bus.out_valid;
    @(negedge clk) lat[0] = bus.out_valid;
    chk("latency", {29'd0, lat}, 32'd1);
    @(posedge clk);
    #1;

    send(16'h0003, 16'h0005, 1'b0);
    send(16'h8000, 16'h0001, 1'b0);
    send(16'h1234, 16'h1234, 1'b0);
    send(16'h1234, 16'h1234, 1'b1);
    idle(5);

    // backpressure: 5 beats against a 6-cycle stall
    bus.out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
        @(negedge clk);
        chk("in_ready_full", {31'd0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) send(rnd_op(), rnd_op(), 1'($urandom_range(0, 1)));
      end
      begin
        repeat (6) @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_stream", {31'd0, bus.out_valid}, 32'd1);
        end
      end
    join
    idle(3);

    // reset with two beats in flight
    bus.out_ready = 1'b0;
    send(16'h00F0, 16'h000F, 1'b0);
    send(16'h0001, 16'h0002, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_valid",    {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid_outputs",  {11'd0, dut_res()},     32'd0);
    chk("rst_mid_in_ready", {31'd0, bus.in_ready},  32'd1);
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    idle(8);

    // random traffic with random backpressure
    fork
      begin
        for (int k = 0; k < 300; k++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          ra = rnd_op();
          rb = ($urandom_range(0, 7) == 0) ? ra : rnd_op();
          send(ra, rb, 1'($urandom_range(0, 1)));
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join

    bus.out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk("drain_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
